// File: rtl/pool_pkg.sv
// Shared types and sizing helpers for the global pooling engine.
// Contents:
//   state_t     - sequencer states (IDLE, ACCUM, RD, CALC, OUT, DONE)
//   mode_t      - pooling operation selected at start (average or max)
//   pool_groups - number of LANES-wide channel groups
//   pool_addr_w - accumulator RAM address width for a given group count
package pool_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    RD,
    CALC,
    OUT,
    DONE
  } state_t;

  typedef enum logic {
    MODE_AVG = 1'b0,
    MODE_MAX = 1'b1
  } mode_t;

  function automatic int pool_groups(input int channels, input int lanes);
    return channels / lanes;
  endfunction

  function automatic int pool_addr_w(input int groups);
    return (groups > 1) ? $clog2(groups) : 1;
  endfunction

endpackage

// File: rtl/global_pool_acc_if.sv
// Valid/ready streaming interface used on both sides of the pooling engine.
// Signals:
//   valid - producer has a word on data
//   ready - consumer accepts the word this cycle
//   data  - WIDTH-bit payload
// Modports: master drives valid/data, slave drives ready.
interface global_pool_acc_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pool_acc_ram.sv
// Simple dual-port accumulator RAM: one write port, one read port with a
// registered (1-cycle) read, written so that it maps onto block RAM.
// Ports:
//   clk          - clock
//   we/waddr/wdata - write port
//   re/raddr     - read request; rdata updates on the next rising edge
//   rdata        - registered read data, held while re is low
module pool_acc_ram #(
  parameter int DEPTH = 2,
  parameter int AW    = 1,
  parameter int W     = 96
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  // NOTE: the array and its read register have no reset; a reset branch on
  // a memory prevents block-RAM inference, and the first-pixel overwrite
  // makes stale contents harmless.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/global_pool_acc.sv
// Global pooling engine. Accumulates num_pixels pixels of LANES-wide channel
// words into a per-group accumulator RAM (sum or max), then streams out one
// pooled word per group: rounded sum*recip clamped to DATA_W bits, or the max.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   start           - run request, accepted in IDLE when num_pixels != 0
//   mode            - 0 average, 1 max (captured on start)
//   num_pixels      - pixels per run (captured on start)
//   recip           - Q0.RECIP_W reciprocal of num_pixels (captured on start)
//   in_if (slave)   - input stream, ready only in ACCUM
//   out_if (master) - pooled output stream
//   busy            - run in progress (state != IDLE)
//   done            - one-cycle pulse after the last output handshake
module global_pool_acc
  import pool_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24,
  parameter int CHANNELS = 1152,
  parameter int PIX_W    = 16,
  parameter int RECIP_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [PIX_W-1:0]   num_pixels,
  input  logic [RECIP_W-1:0] recip,
  global_pool_acc_if.slave   in_if,
  global_pool_acc_if.master  out_if,
  output logic               busy,
  output logic               done
);

  localparam int GROUPS = pool_groups(CHANNELS, LANES);
  localparam int AW     = pool_addr_w(GROUPS);
  localparam int WORD_W = LANES * DATA_W;
  localparam int RAM_W  = LANES * ACC_W;
  localparam int PROD_W = ACC_W + RECIP_W + 1;
  localparam logic [AW-1:0] LAST_GRP = AW'(GROUPS - 1);

  // Accumulate step for one lane: first pixel overwrites, later pixels add
  // (wrapping) or take the max.
  function automatic logic [ACC_W-1:0] acc_lane(input logic [ACC_W-1:0] acc,
                                                input logic [DATA_W-1:0] d,
                                                input logic first,
                                                input logic is_max);
    logic [ACC_W-1:0] ext;
    ext = ACC_W'(d);
    if (first) return ext;
    if (is_max) return (acc > ext) ? acc : ext;
    return acc + ext;
  endfunction

  // Average readout for one lane: round-half-up fixed-point scale, clamp.
  function automatic logic [DATA_W-1:0] avg_lane(input logic [ACC_W-1:0] acc,
                                                 input logic [RECIP_W-1:0] r);
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] scaled;
    prod   = PROD_W'(acc) * PROD_W'(r) + (PROD_W'(1) << (RECIP_W - 1));
    scaled = prod >> RECIP_W;
    if (|scaled[PROD_W-1:DATA_W]) return '1;
    return scaled[DATA_W-1:0];
  endfunction

  state_t             state_q, state_d;
  logic [AW-1:0]      grp_cnt_q, grp_cnt_d;
  logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [PIX_W-1:0]   npix_q, npix_d;
  mode_t              mode_q, mode_d;
  logic [RECIP_W-1:0] recip_q, recip_d;
  // Pending read-modify-write captured on the accept cycle.
  logic               wr_en_q, wr_en_d;
  logic [AW-1:0]      wr_addr_q, wr_addr_d;
  logic               wr_first_q, wr_first_d;
  logic [WORD_W-1:0]  wr_word_q, wr_word_d;
  logic [WORD_W-1:0]  out_data_q, out_data_d;

  logic               accept;
  logic               ram_re;
  logic [AW-1:0]      ram_raddr;
  logic [RAM_W-1:0]   ram_rdata;
  logic [RAM_W-1:0]   ram_wdata;
  logic [WORD_W-1:0]  pooled;

  assign accept = (state_q == ACCUM) && in_if.valid;

  pool_acc_ram #(
    .DEPTH(GROUPS),
    .AW   (AW),
    .W    (RAM_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en_q),
    .waddr(wr_addr_q),
    .wdata(ram_wdata),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  // The RAM read issued on the accept cycle is valid exactly when the pending
  // write is applied, so the write data is formed straight from rdata.
  always_comb begin
    ram_wdata = '0;
    pooled    = '0;
    for (int k = 0; k < LANES; k++) begin
      ram_wdata[k*ACC_W +: ACC_W] = acc_lane(ram_rdata[k*ACC_W +: ACC_W],
                                             wr_word_q[k*DATA_W +: DATA_W],
                                             wr_first_q, mode_q == MODE_MAX);
      pooled[k*DATA_W +: DATA_W]  = (mode_q == MODE_MAX)
                                  ? ram_rdata[k*ACC_W +: DATA_W]
                                  : avg_lane(ram_rdata[k*ACC_W +: ACC_W], recip_q);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    grp_cnt_d  = grp_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    npix_d     = npix_q;
    mode_d     = mode_q;
    recip_d    = recip_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_first_d = wr_first_q;
    wr_word_d  = wr_word_q;
    out_data_d = out_data_q;
    ram_re     = 1'b0;
    ram_raddr  = grp_cnt_q;

    case (state_q)
      IDLE: begin
        if (start && (num_pixels != '0)) begin
          state_d   = ACCUM;
          grp_cnt_d = '0;
          pix_cnt_d = '0;
          npix_d    = num_pixels;
          mode_d    = mode_t'(mode);
          recip_d   = recip;
        end
      end
      ACCUM: begin
        if (accept) begin
          ram_re     = 1'b1;
          wr_en_d    = 1'b1;
          wr_addr_d  = grp_cnt_q;
          wr_first_d = (pix_cnt_q == '0);
          wr_word_d  = in_if.data;
          if (grp_cnt_q == LAST_GRP) begin
            grp_cnt_d = '0;
            pix_cnt_d = pix_cnt_q + PIX_W'(1);
            if (pix_cnt_q == npix_q - PIX_W'(1)) state_d = RD;
          end else begin
            grp_cnt_d = grp_cnt_q + AW'(1);
          end
        end
      end
      RD: begin
        ram_re  = 1'b1;
        state_d = CALC;
      end
      CALC: begin
        out_data_d = pooled;
        state_d    = OUT;
      end
      OUT: begin
        if (out_if.ready) begin
          if (grp_cnt_q == LAST_GRP) begin
            grp_cnt_d = '0;
            state_d   = DONE;
          end else begin
            grp_cnt_d = grp_cnt_q + AW'(1);
            state_d   = RD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grp_cnt_q  <= '0;
      pix_cnt_q  <= '0;
      npix_q     <= '0;
      mode_q     <= MODE_AVG;
      recip_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_first_q <= 1'b0;
      wr_word_q  <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      grp_cnt_q  <= grp_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      npix_q     <= npix_d;
      mode_q     <= mode_d;
      recip_q    <= recip_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_first_q <= wr_first_d;
      wr_word_q  <= wr_word_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_if.ready  = (state_q == ACCUM);
  assign out_if.valid = (state_q == OUT);
  assign out_if.data  = out_data_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);

endmodule
